// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds dispatched micro-ops until both source
// operands are ready. Operands wake up by snooping two writeback tag
// broadcasts. Each cycle the lowest-index ready entry is offered to issue.
module alu_reservation_station #(
  parameter int RS_DEPTH      = 8,
  parameter int PHY_WIDTH     = 6,
  parameter int ROB_WIDTH     = 5,
  parameter int PAYLOAD_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [ROB_WIDTH-1:0]       disp_rob_id,
  input  logic [PHY_WIDTH-1:0]       disp_prd,
  input  logic [PHY_WIDTH-1:0]       disp_prs1,
  input  logic [PHY_WIDTH-1:0]       disp_prs2,
  input  logic                       disp_rs1_rdy,
  input  logic                       disp_rs2_rdy,
  input  logic [PAYLOAD_WIDTH-1:0]   disp_payload,
  input  logic [1:0]                 wb_valid,
  input  logic [2*PHY_WIDTH-1:0]     wb_tag,
  output logic                       iss_valid,
  input  logic                       iss_ready,
  output logic [ROB_WIDTH-1:0]       iss_rob_id,
  output logic [PHY_WIDTH-1:0]       iss_prd,
  output logic [PHY_WIDTH-1:0]       iss_prs1,
  output logic [PHY_WIDTH-1:0]       iss_prs2,
  output logic [PAYLOAD_WIDTH-1:0]   iss_payload,
  output logic [$clog2(RS_DEPTH):0]  count,
  output logic                       empty
);

  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RS_DEPTH);

  // Per-entry status bits (reset/flush cleared) and payload fields (no reset).
  logic [RS_DEPTH-1:0]      valid_reg, valid_next;
  logic [RS_DEPTH-1:0]      rdy1_reg, rdy1_next;
  logic [RS_DEPTH-1:0]      rdy2_reg, rdy2_next;
  logic [ROB_WIDTH-1:0]     rob_id_reg  [RS_DEPTH];
  logic [PHY_WIDTH-1:0]     prd_reg     [RS_DEPTH];
  logic [PHY_WIDTH-1:0]     prs1_reg    [RS_DEPTH];
  logic [PHY_WIDTH-1:0]     prs2_reg    [RS_DEPTH];
  logic [PAYLOAD_WIDTH-1:0] payload_reg [RS_DEPTH];
  logic [CNT_W-1:0]         count_reg, count_next;

  logic [PHY_WIDTH-1:0] wb_tag0, wb_tag1;
  logic [RS_DEPTH-1:0]  ready_vec, alloc_hit, issue_hit, wake1, wake2;
  logic [IDX_W-1:0]     alloc_idx, sel_idx;
  logic                 disp_fire, iss_fire, disp_rdy1, disp_rdy2;

  assign wb_tag0 = wb_tag[PHY_WIDTH-1:0];
  assign wb_tag1 = wb_tag[2*PHY_WIDTH-1:PHY_WIDTH];

  // Handshakes are derived from registered state only, so a slot freed by
  // issue this cycle cannot be refilled until the next cycle.
  assign disp_ready = !flush && (count_reg < DEPTH_C);
  assign disp_fire  = disp_valid && disp_ready;
  assign ready_vec  = valid_reg & rdy1_reg & rdy2_reg;
  assign iss_valid  = !flush && (|ready_vec);
  assign iss_fire   = iss_valid && iss_ready;

  // Source readiness at dispatch, including a same-cycle broadcast bypass so
  // a wakeup coinciding with dispatch is never lost. Tag 0 is always ready.
  assign disp_rdy1 = disp_rs1_rdy || (disp_prs1 == '0) ||
                     (wb_valid[0] && wb_tag0 == disp_prs1) ||
                     (wb_valid[1] && wb_tag1 == disp_prs1);
  assign disp_rdy2 = disp_rs2_rdy || (disp_prs2 == '0) ||
                     (wb_valid[0] && wb_tag0 == disp_prs2) ||
                     (wb_valid[1] && wb_tag1 == disp_prs2);

  // Lowest-index free entry receives the next dispatch.
  always_comb begin
    alloc_idx = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!valid_reg[i]) alloc_idx = IDX_W'(i);
    end
  end

  // Lowest-index ready entry is the issue candidate.
  always_comb begin
    sel_idx = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (ready_vec[i]) sel_idx = IDX_W'(i);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < RS_DEPTH; gi++) begin : g_entry
      assign alloc_hit[gi] = disp_fire && (alloc_idx == IDX_W'(gi));
      assign issue_hit[gi] = iss_fire && (sel_idx == IDX_W'(gi));
      assign wake1[gi] = (wb_valid[0] && wb_tag0 == prs1_reg[gi]) ||
                         (wb_valid[1] && wb_tag1 == prs1_reg[gi]);
      assign wake2[gi] = (wb_valid[0] && wb_tag0 == prs2_reg[gi]) ||
                         (wb_valid[1] && wb_tag1 == prs2_reg[gi]);
      // Allocation targets only invalid entries and issue only valid ones,
      // so the two never collide on the same slot.
      assign valid_next[gi] = alloc_hit[gi] ? 1'b1 :
                              (issue_hit[gi] ? 1'b0 : valid_reg[gi]);
      assign rdy1_next[gi]  = alloc_hit[gi] ? disp_rdy1 : (rdy1_reg[gi] | wake1[gi]);
      assign rdy2_next[gi]  = alloc_hit[gi] ? disp_rdy2 : (rdy2_reg[gi] | wake2[gi]);
    end
  endgenerate

  assign count_next = count_reg + CNT_W'(disp_fire) - CNT_W'(iss_fire);

  // Status state: reset and flush both empty the station.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_reg <= '0;
      rdy1_reg  <= '0;
      rdy2_reg  <= '0;
      count_reg <= '0;
    end else begin
      valid_reg <= valid_next;
      rdy1_reg  <= rdy1_next;
      rdy2_reg  <= rdy2_next;
      count_reg <= count_next;
    end
  end

  // Entry field storage, written only on an accepted dispatch.
  always_ff @(posedge clk) begin
    if (disp_fire) begin
      rob_id_reg[alloc_idx]  <= disp_rob_id;
      prd_reg[alloc_idx]     <= disp_prd;
      prs1_reg[alloc_idx]    <= disp_prs1;
      prs2_reg[alloc_idx]    <= disp_prs2;
      payload_reg[alloc_idx] <= disp_payload;
    end
  end

  assign iss_rob_id  = iss_valid ? rob_id_reg[sel_idx]  : '0;
  assign iss_prd     = iss_valid ? prd_reg[sel_idx]     : '0;
  assign iss_prs1    = iss_valid ? prs1_reg[sel_idx]    : '0;
  assign iss_prs2    = iss_valid ? prs2_reg[sel_idx]    : '0;
  assign iss_payload = iss_valid ? payload_reg[sel_idx] : '0;
  assign count       = count_reg;
  assign empty       = (count_reg == '0);

  // Occupancy bound and well-defined issue fields.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (count_reg <= DEPTH_C);
      if (iss_valid)
        assert (!$isunknown({iss_rob_id, iss_prd, iss_prs1, iss_prs2, iss_payload}));
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station. Stimulus pushes expected issue
// records into a queue; a negedge monitor pops and compares on each issue.
module tb_alu_reservation_station;

  logic        clk, rst, flush;
  logic        disp_valid, disp_ready;
  logic [4:0]  disp_rob_id;
  logic [5:0]  disp_prd, disp_prs1, disp_prs2;
  logic        disp_rs1_rdy, disp_rs2_rdy;
  logic [31:0] disp_payload;
  logic [1:0]  wb_valid;
  logic [11:0] wb_tag;
  logic        iss_valid, iss_ready;
  logic [4:0]  iss_rob_id;
  logic [5:0]  iss_prd, iss_prs1, iss_prs2;
  logic [31:0] iss_payload;
  logic [3:0]  count;
  logic        empty;

  alu_reservation_station dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_rob_id(disp_rob_id), .disp_prd(disp_prd),
    .disp_prs1(disp_prs1), .disp_prs2(disp_prs2),
    .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
    .disp_payload(disp_payload),
    .wb_valid(wb_valid), .wb_tag(wb_tag),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rob_id(iss_rob_id), .iss_prd(iss_prd),
    .iss_prs1(iss_prs1), .iss_prs2(iss_prs2), .iss_payload(iss_payload),
    .count(count), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rob;
    logic [5:0]  prd;
    logic [31:0] pay;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [5:0] prd_of(input logic [4:0] rob);
    return {1'b0, rob} + 6'd1;
  endfunction

  function automatic logic [31:0] pay_of(input logic [4:0] rob);
    return 32'hC0DE_0000 | {27'd0, rob};
  endfunction

  task automatic exp_push(input logic [4:0] rob);
    exp_t e;
    e.rob = rob;
    e.prd = prd_of(rob);
    e.pay = pay_of(rob);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("check %s = %0h ok", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [4:0] rob, input logic [5:0] p1, input logic [5:0] p2,
                      input logic r1, input logic r2);
    disp_valid   = 1'b1;
    disp_rob_id  = rob;
    disp_prd     = prd_of(rob);
    disp_prs1    = p1;
    disp_prs2    = p2;
    disp_rs1_rdy = r1;
    disp_rs2_rdy = r2;
    disp_payload = pay_of(rob);
  endtask

  task automatic bcast(input logic v0, input logic [5:0] t0, input logic v1, input logic [5:0] t1);
    wb_valid = {v1, v0};
    wb_tag   = {t1, t0};
  endtask

  // Issue monitor: every accepted issue must match the head of the queue.
  always @(negedge clk) begin
    if (!rst && iss_valid && iss_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL issue_unexpected: got rob %0d, expected no issue", iss_rob_id);
      end else begin
        mon_e = exp_q.pop_front();
        if (iss_rob_id !== mon_e.rob || iss_prd !== mon_e.prd || iss_payload !== mon_e.pay) begin
          n_err++;
          $display("FAIL issue_fields: got rob %0d prd %0d pay %0h, expected rob %0d prd %0d pay %0h",
                   iss_rob_id, iss_prd, iss_payload, mon_e.rob, mon_e.prd, mon_e.pay);
        end else begin
          $display("issue rob %0d prd %0d pay %0h ok", iss_rob_id, iss_prd, iss_payload);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; iss_ready = 1'b0;
    disp_valid = 1'b0; disp_rob_id = '0; disp_prd = '0; disp_prs1 = '0; disp_prs2 = '0;
    disp_rs1_rdy = 1'b0; disp_rs2_rdy = 1'b0; disp_payload = '0;
    wb_valid = '0; wb_tag = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_disp_ready", 32'(disp_ready), 1);
    chk("rst_iss_valid", 32'(iss_valid), 0);
    chk("rst_iss_rob", 32'(iss_rob_id), 0);

    // Ready dispatch: visible one cycle after dispatch, count 0->1->0
    tick();
    iss_ready = 1'b1;
    disp(5'd3, 6'd1, 6'd2, 1'b1, 1'b1);
    exp_push(5'd3);
    @(negedge clk);
    chk("rd_iv_same", 32'(iss_valid), 0);
    chk("rd_count0", 32'(count), 0);
    tick(); disp_valid = 1'b0;
    @(negedge clk);
    chk("rd_iv", 32'(iss_valid), 1);
    chk("rd_rob", 32'(iss_rob_id), 3);
    chk("rd_count1", 32'(count), 1);
    tick();
    @(negedge clk);
    chk("rd_count2", 32'(count), 0);
    chk("rd_empty", 32'(empty), 1);

    // Wakeup via port 1 three cycles after dispatch; prs2 is tag 0
    tick();
    disp(5'd4, 6'd12, 6'd0, 1'b0, 1'b0);
    tick(); disp_valid = 1'b0;
    @(negedge clk); chk("wk_iv_c1", 32'(iss_valid), 0);
    tick();
    @(negedge clk); chk("wk_iv_c2", 32'(iss_valid), 0);
    tick();
    bcast(1'b0, 6'd0, 1'b1, 6'd12);
    exp_push(5'd4);
    @(negedge clk); chk("wk_iv_bcast", 32'(iss_valid), 0);
    tick(); bcast(1'b0, 6'd0, 1'b0, 6'd0);
    @(negedge clk);
    chk("wk_iv", 32'(iss_valid), 1);
    chk("wk_rob", 32'(iss_rob_id), 4);
    tick();

    // Same-cycle bypass on port 0
    disp(5'd5, 6'd7, 6'd9, 1'b0, 1'b1);
    bcast(1'b1, 6'd7, 1'b0, 6'd0);
    exp_push(5'd5);
    tick(); disp_valid = 1'b0; bcast(1'b0, 6'd0, 1'b0, 6'd0);
    @(negedge clk);
    chk("bp_iv", 32'(iss_valid), 1);
    chk("bp_rob", 32'(iss_rob_id), 5);
    tick();
    @(negedge clk); chk("bp_empty", 32'(empty), 1);

    // Fill all 8 entries with unready ops (entry i holds rob 10+i, prs1 20+i)
    tick();
    for (int i = 0; i < 8; i++) begin
      disp(5'(10 + i), 6'(20 + i), 6'd30, 1'b0, 1'b1);
      tick();
    end
    // Cycle A: full, wake entry 5, hold a ready dispatch (rob 20) pending
    iss_ready = 1'b0;
    disp(5'd20, 6'd0, 6'd0, 1'b1, 1'b1);
    bcast(1'b1, 6'd25, 1'b0, 6'd0);
    @(negedge clk);
    chk("full_count", 32'(count), 8);
    chk("full_disp_ready", 32'(disp_ready), 0);
    chk("full_iv", 32'(iss_valid), 0);
    tick(); bcast(1'b0, 6'd0, 1'b0, 6'd0);
    // Cycle B: entry 5 ready but stalled
    @(negedge clk);
    chk("stall_iv", 32'(iss_valid), 1);
    chk("stall_rob", 32'(iss_rob_id), 15);
    tick();
    // Cycle C: still presenting rob 15; accept it now
    iss_ready = 1'b1;
    exp_push(5'd15);
    @(negedge clk);
    chk("hold_rob", 32'(iss_rob_id), 15);
    chk("hold_disp_ready", 32'(disp_ready), 0);
    chk("hold_count", 32'(count), 8);
    tick();
    // Cycle D: slot free, pending dispatch accepted into entry 5
    @(negedge clk);
    chk("free_count", 32'(count), 7);
    chk("free_disp_ready", 32'(disp_ready), 1);
    chk("free_iv", 32'(iss_valid), 0);
    exp_push(5'd20);
    tick(); disp_valid = 1'b0;
    @(negedge clk);
    chk("refill_rob", 32'(iss_rob_id), 20);
    chk("refill_count", 32'(count), 8);
    tick();
    @(negedge clk); chk("after_refill_count", 32'(count), 7);

    // Priority: entries 2 and 6 woken together
    bcast(1'b1, 6'd22, 1'b1, 6'd26);
    exp_push(5'd12);
    exp_push(5'd16);
    tick(); bcast(1'b0, 6'd0, 1'b0, 6'd0);
    @(negedge clk); chk("prio_first", 32'(iss_rob_id), 12);
    tick();
    @(negedge clk); chk("prio_second", 32'(iss_rob_id), 16);
    tick();
    @(negedge clk);
    chk("prio_count", 32'(count), 5);
    chk("prio_iv", 32'(iss_valid), 0);

    // Flush: wake entry 0 first so flush must suppress a real candidate
    bcast(1'b1, 6'd20, 1'b0, 6'd0);
    tick(); bcast(1'b0, 6'd0, 1'b0, 6'd0);
    flush = 1'b1;
    disp(5'd30, 6'd0, 6'd0, 1'b1, 1'b1);
    @(negedge clk);
    chk("fl_iv", 32'(iss_valid), 0);
    chk("fl_disp_ready", 32'(disp_ready), 0);
    tick(); flush = 1'b0; disp_valid = 1'b0;
    @(negedge clk);
    chk("fl_count", 32'(count), 0);
    chk("fl_empty", 32'(empty), 1);
    chk("fl_iv_after", 32'(iss_valid), 0);
    chk("fl_disp_ready_after", 32'(disp_ready), 1);
    bcast(1'b1, 6'd21, 1'b1, 6'd23);
    tick();
    bcast(1'b1, 6'd24, 1'b1, 6'd27);
    tick(); bcast(1'b0, 6'd0, 1'b0, 6'd0);
    repeat (3) tick();
    @(negedge clk); chk("fl_quiet", 32'(iss_valid), 0);

    // Reset mid-operation
    tick();
    iss_ready = 1'b0;
    disp(5'd9, 6'd0, 6'd0, 1'b1, 1'b1);
    tick(); disp_valid = 1'b0;
    @(negedge clk);
    chk("mr_iv", 32'(iss_valid), 1);
    chk("mr_count", 32'(count), 1);
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("mr_count_after", 32'(count), 0);
    chk("mr_iv_after", 32'(iss_valid), 0);
    chk("mr_rob_after", 32'(iss_rob_id), 0);
    chk("mr_disp_ready", 32'(disp_ready), 1);

    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
